// File: rtl/apb_controller_if.sv
// AHB-side and APB-side signal bundle of the AHB-to-APB bridge controller.
// The slave modport is the controller's view; master is the surrounding system's view.
interface apb_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic [ADDR_WIDTH-1:0] Haddr;
    logic                  Hwrite;
    logic [2:0]            tempselx;
    logic [DATA_WIDTH-1:0] Hwdata;
    logic [DATA_WIDTH-1:0] Prdata;
    logic                  Pwrite;
    logic [2:0]            Pselx;
    logic                  Penable;
    logic [ADDR_WIDTH-1:0] Paddr;
    logic [DATA_WIDTH-1:0] Pwdata;
    logic                  Hreadyout;
    logic [DATA_WIDTH-1:0] Hrdata;

    modport slave (
        input  valid, Haddr, Hwrite, tempselx, Hwdata, Prdata,
        output Pwrite, Pselx, Penable, Paddr, Pwdata, Hreadyout, Hrdata
    );

    modport master (
        output valid, Haddr, Hwrite, tempselx, Hwdata, Prdata,
        input  Pwrite, Pselx, Penable, Paddr, Pwdata, Hreadyout, Hrdata
    );
endinterface

// File: rtl/apb_controller.sv
// AHB-to-APB bridge controller: Moore FSM turning qualified AHB transfers into APB setup/enable phases.
// Optional macro APB_RDATA_HOLD_EN keeps the last APB read data on Hrdata outside the read enable phase.
module apb_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic              Hclk,
    input logic              Hreset,
    apb_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WENABLE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            sel_q, sel_d;
    logic                  write_q, write_d;
    logic                  accept;
    logic                  busPhase;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            paddr_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            paddr_q <= paddr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            write_q <= write_d;
        end
    end

    // A transfer can only be accepted while Hreadyout is high (idle or an enable phase).
    always_comb begin
        accept  = bus.valid && (state_q == ST_IDLE || state_q == ST_RENABLE ||
                                state_q == ST_WENABLE);
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        write_d = write_q;
        wdata_d = wdata_q;
        paddr_d = paddr_q;

        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (accept) begin
                    state_d = bus.Hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_RENABLE;
            ST_WWAIT: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_WENABLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            addr_d  = bus.Haddr;
            sel_d   = bus.tempselx;
            write_d = bus.Hwrite;
        end

        if (state_q == ST_WWAIT) begin
            wdata_d = bus.Hwdata;
        end

        // Paddr only moves when a setup phase starts, so it holds while Pselx is low.
        if (state_d == ST_READ || state_d == ST_WRITE) begin
            paddr_d = addr_d;
        end
    end

    assign busPhase = (state_q == ST_READ)  || (state_q == ST_RENABLE) ||
                      (state_q == ST_WRITE) || (state_q == ST_WENABLE);

    assign bus.Pselx     = busPhase ? sel_q : 3'b000;
    assign bus.Pwrite    = busPhase && write_q;
    assign bus.Penable   = (state_q == ST_RENABLE) || (state_q == ST_WENABLE);
    assign bus.Hreadyout = (state_q == ST_IDLE) || (state_q == ST_RENABLE) ||
                           (state_q == ST_WENABLE);
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = wdata_q;

`ifdef APB_RDATA_HOLD_EN
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            rdata_q <= '0;
        end else if (state_q == ST_RENABLE) begin
            rdata_q <= bus.Prdata;
        end
    end

    assign bus.Hrdata = (state_q == ST_RENABLE) ? bus.Prdata : rdata_q;
`else
    assign bus.Hrdata = bus.Prdata;
`endif
endmodule
